// File: rtl/sd_pkg.sv
// Types and constants shared by the SD command transmit and response receive paths.
// The CRC7 polynomial is x^7 + x^3 + 1, written without the implicit x^7 term.
package sd_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RECV, DONE} sd_rsp_state_t;

  localparam logic [6:0] SD_CRC7_POLY = 7'h09;
  localparam int         SD_FRAME_LEN = 48;

  typedef struct packed {
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic        crc_err;
    logic        frm_err;
    logic        timeout;
  } sd_rsp_t;

endpackage

// File: rtl/sd_rsp_rx_if.sv
// Response receiver handshake: arm/config from the controller, CMD line from the card,
// and the decoded response presented back to the register interface.
interface sd_rsp_rx_if;

  logic        arm;
  logic        crc_chk;
  logic        i_sd_cmd;
  logic        busy;
  logic        rsp_valid;
  logic [5:0]  rsp_cmd;
  logic [31:0] rsp_arg;
  logic        rsp_crc_err;
  logic        rsp_frm_err;
  logic        rsp_timeout;

  modport master (
    output arm, crc_chk, i_sd_cmd,
    input  busy, rsp_valid, rsp_cmd, rsp_arg, rsp_crc_err, rsp_frm_err, rsp_timeout
  );

  modport slave (
    input  arm, crc_chk, i_sd_cmd,
    output busy, rsp_valid, rsp_cmd, rsp_arg, rsp_crc_err, rsp_frm_err, rsp_timeout
  );

endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per clock, MSB first; clr has priority over en.
// Result is visible on crc the cycle after the last enabled bit.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = din ^ crc_q[6];
    crc_d = crc_q;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_rsp_rx.sv
// SD CMD-line 48-bit response receiver: start/NCR timeout detection, shift-in, CRC7 and framing checks.
// rsp_valid pulses one edge after the end bit (or NCR_MAX+1 edges after arm on timeout); results hold until the next arm.
module sd_rsp_rx
  import sd_pkg::*;
#(
  parameter int NCR_MAX   = 64,
  parameter int FRAME_LEN = SD_FRAME_LEN
) (
  input  logic        clk,
  input  logic        rst,
  sd_rsp_rx_if.slave  rx
);

  localparam int NCW = $clog2(NCR_MAX + 1);

  sd_rsp_state_t        state_q, state_d;
  logic [5:0]           bit_cnt_q, bit_cnt_d;
  logic [NCW-1:0]       ncr_cnt_q, ncr_cnt_d;
  logic [FRAME_LEN-1:0] sr_q, sr_d;
  logic                 to_q, to_d;
  logic                 vld_q, vld_d;
  sd_rsp_t              res_q, res_d;
  logic                 crc_clr, crc_en;
  logic [6:0]           crc;

  sd_crc7 u_crc7 (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (rx.i_sd_cmd),
    .crc (crc)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    ncr_cnt_d = ncr_cnt_q;
    sr_d      = sr_q;
    to_d      = to_q;
    vld_d     = 1'b0;
    res_d     = res_q;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;

    case (state_q)
      IDLE: ;
      WAIT: begin
        if (!rx.i_sd_cmd) begin
          // Start bit is bit 47; it is zero so it leaves the cleared CRC unchanged.
          state_d   = RECV;
          bit_cnt_d = 6'd1;
          sr_d      = {sr_q[FRAME_LEN-2:0], rx.i_sd_cmd};
          crc_clr   = 1'b1;
        end else if (ncr_cnt_q == NCW'(NCR_MAX - 1)) begin
          state_d = DONE;
          to_d    = 1'b1;
        end else begin
          ncr_cnt_d = ncr_cnt_q + NCW'(1);
        end
      end
      RECV: begin
        sr_d      = {sr_q[FRAME_LEN-2:0], rx.i_sd_cmd};
        bit_cnt_d = bit_cnt_q + 6'd1;
        crc_en    = (bit_cnt_q < 6'(FRAME_LEN - 8));
        if (bit_cnt_q == 6'(FRAME_LEN - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        vld_d   = 1'b1;
        state_d = IDLE;
        res_d   = '0;
        if (to_q) begin
          res_d.timeout = 1'b1;
        end else begin
          res_d.cmd     = sr_q[45:40];
          res_d.arg     = sr_q[39:8];
          res_d.crc_err = rx.crc_chk && (crc != sr_q[7:1]);
          // The start bit is zero by construction; checking it alongside the others is free.
          res_d.frm_err = sr_q[47] | sr_q[46] | ~sr_q[0];
        end
      end
      default: ;
    endcase

    // A new arm restarts the receiver; a response finishing this very cycle is still reported.
    if (rx.arm) begin
      state_d   = WAIT;
      bit_cnt_d = '0;
      ncr_cnt_d = '0;
      sr_d      = '0;
      to_d      = 1'b0;
      crc_clr   = 1'b1;
      crc_en    = 1'b0;
      if (state_q != DONE) begin
        res_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      ncr_cnt_q <= '0;
      sr_q      <= '0;
      to_q      <= 1'b0;
      vld_q     <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ncr_cnt_q <= ncr_cnt_d;
      sr_q      <= sr_d;
      to_q      <= to_d;
      vld_q     <= vld_d;
      res_q     <= res_d;
    end
  end

  assign rx.busy        = (state_q != IDLE) && !vld_q;
  assign rx.rsp_valid   = vld_q;
  assign rx.rsp_cmd     = res_q.cmd;
  assign rx.rsp_arg     = res_q.arg;
  assign rx.rsp_crc_err = res_q.crc_err;
  assign rx.rsp_frm_err = res_q.frm_err;
  assign rx.rsp_timeout = res_q.timeout;

endmodule

// File: tb/tb_sd_rsp_rx.sv
// Bench for sd_rsp_rx: a transaction-level model schedules each expected response by edge number
// and one per-cycle compare process checks every output against it.
module tb_sd_rsp_rx;
  import sd_pkg::*;

  localparam int NCR_MAX = 64;

  typedef struct {
    int      at;
    sd_rsp_t r;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_rsp_rx_if bus ();

  sd_rsp_rx #(.NCR_MAX(NCR_MAX), .FRAME_LEN(48)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (bus.slave)
  );

  int      checks = 0;
  int      failures = 0;
  int      cyc = 0;
  int      n_vld = 0;
  int      last_vld_cyc = -1;
  ev_t     ev_q[$];
  sd_rsp_t held = '0;
  int      clr_at = -1;
  int      arm_at = -1;
  int      end_at = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // CRC7 as polynomial long division of the 40 covered bits times x^7 by x^7+x^3+1.
  function automatic logic [6:0] crc7_model(input logic [39:0] d);
    logic [46:0] v;
    v = {d, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (v[i]) v[i-:8] = v[i-:8] ^ 8'h89;
    end
    return v[6:0];
  endfunction

  function automatic sd_rsp_t rsp_model(input logic [47:0] f, input bit chk);
    sd_rsp_t r;
    r.cmd     = f[45:40];
    r.arg     = f[39:8];
    r.crc_err = chk && (crc7_model(f[47:8]) != f[7:1]);
    r.frm_err = f[46] || !f[0];
    r.timeout = 1'b0;
    return r;
  endfunction

  // Arm at edge a: any response due after a is aborted; one due exactly at a survives.
  task automatic m_arm(input int a, input int v, input sd_rsp_t r);
    while (ev_q.size() > 0 && ev_q[$].at > a) void'(ev_q.pop_back());
    ev_q.push_back('{at: v, r: r});
    clr_at = a;
    arm_at = a;
    end_at = v;
  endtask

  task automatic m_reset();
    ev_q.delete();
    held   = '0;
    clr_at = -1;
    end_at = -1;
  endtask

  initial begin
    bit      ev;
    bit      eb;
    sd_rsp_t er;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      ev = 1'b0;
      er = '0;
      if (ev_q.size() > 0 && ev_q[0].at == cyc) begin
        ev = 1'b1;
        er = ev_q[0].r;
        void'(ev_q.pop_front());
      end
      if (cyc == clr_at) held = '0;
      if (ev) held = er;
      eb = (end_at > 0) && (cyc >= arm_at) && (cyc < end_at) && !ev;
      check("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
      check("busy", 64'(bus.busy), 64'(eb));
      check("rsp_fields",
            64'({bus.rsp_cmd, bus.rsp_arg, bus.rsp_crc_err, bus.rsp_frm_err, bus.rsp_timeout}),
            64'(held));
      if (bus.rsp_valid) begin
        n_vld++;
        last_vld_cyc = cyc;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.arm      = 1'b0;
      bus.i_sd_cmd = 1'b1;
    end
  endtask

  // Arm, hold the line high for gap edges, then drive the top nbits of f MSB-first.
  task automatic run(input logic [47:0] f, input bit chk, input int gap, input int nbits, input bit to);
    int      a;
    sd_rsp_t r;
    @(negedge clk);
    bus.arm      = 1'b1;
    bus.crc_chk  = chk;
    bus.i_sd_cmd = 1'b1;
    a = cyc + 1;
    if (to) begin
      r = '0;
      r.timeout = 1'b1;
      m_arm(a, a + NCR_MAX + 1, r);
    end else begin
      m_arm(a, a + gap + 49, rsp_model(f, chk));
    end
    for (int i = 0; i < gap + nbits; i++) begin
      @(negedge clk);
      bus.arm      = 1'b0;
      bus.i_sd_cmd = (i < gap) ? 1'b1 : f[47-(i-gap)];
    end
  endtask

  task automatic chk_rsp(input string tag, input logic [5:0] c, input logic [31:0] a,
                         input logic [2:0] flags);
    check({tag, "_cmd"}, 64'(bus.rsp_cmd), 64'(c));
    check({tag, "_arg"}, 64'(bus.rsp_arg), 64'(a));
    check({tag, "_flags"}, 64'({bus.rsp_crc_err, bus.rsp_frm_err, bus.rsp_timeout}), 64'(flags));
  endtask

  initial begin
    int v0;
    bus.arm      = 1'b0;
    bus.crc_chk  = 1'b0;
    bus.i_sd_cmd = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    chk_rsp("reset", 6'd0, 32'd0, 3'b000);
    rst = 1'b1;
    idle(3);

    check("model_crc_r7", 64'(crc7_model(40'h08000001AA)), 64'h09);
    check("model_crc_r1", 64'(crc7_model(40'h3700000120)), 64'h41);

    run(48'h08000001AA13, 1'b1, 2, 48, 1'b0); idle(4);
    chk_rsp("r7", 6'd8, 32'h000001AA, 3'b000);

    run(48'h370000012083, 1'b1, 2, 48, 1'b0); idle(4);
    chk_rsp("r1", 6'd55, 32'h00000120, 3'b000);

    run(48'h3F00FF8000FF, 1'b0, 3, 48, 1'b0); idle(4);
    chk_rsp("r3_nochk", 6'd63, 32'h00FF8000, 3'b000);
    run(48'h3F00FF8000FF, 1'b1, 3, 48, 1'b0); idle(4);
    chk_rsp("r3_chk", 6'd63, 32'h00FF8000, 3'b100);

    run(48'h0, 1'b1, NCR_MAX + 2, 0, 1'b1); idle(4);
    chk_rsp("timeout", 6'd0, 32'd0, 3'b001);
    check("timeout_latency", 64'(last_vld_cyc - arm_at), 64'(NCR_MAX + 1));

    run(48'h08000001AA12, 1'b1, 2, 48, 1'b0); idle(4);
    chk_rsp("end_bit", 6'd8, 32'h000001AA, 3'b010);
    run(48'h48000001AA13, 1'b1, 2, 48, 1'b0); idle(4);
    chk_rsp("tx_bit", 6'd8, 32'h000001AA, 3'b110);

    v0 = n_vld;
    run(48'h08000001AA13, 1'b1, 2, 20, 1'b0);
    @(negedge clk);
    rst          = 1'b0;
    bus.i_sd_cmd = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    chk_rsp("midrst", 6'd0, 32'd0, 3'b000);
    rst = 1'b1;
    idle(40);
    check("midrst_no_valid", 64'(n_vld - v0), 64'd0);

    v0 = n_vld;
    run(48'h08000001AA13, 1'b1, 2, 20, 1'b0);
    run(48'h370000012083, 1'b1, 2, 48, 1'b0); idle(4);
    check("rearm_one_valid", 64'(n_vld - v0), 64'd1);
    chk_rsp("rearm", 6'd55, 32'h00000120, 3'b000);

    v0 = n_vld;
    run(48'h08000001AA13, 1'b1, 2, 48, 1'b0);
    run(48'h370000012083, 1'b1, 1, 48, 1'b0); idle(4);
    check("arm_in_done_valids", 64'(n_vld - v0), 64'd2);
    chk_rsp("arm_in_done", 6'd55, 32'h00000120, 3'b000);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
